div_tick_detect: RTL and testbench
==================================

# div_tick_detect

Receiving end of the clock-divider path. Takes a slow divided-clock signal `div_in`, which is asynchronous or derived from a ripple divider, into the `clk` domain. It synchronises the signal, emits single-cycle `tick` enables on its edges, and measures its period in `clk` cycles. Downstream logic, such as the Game of Life generation stepper, uses `tick` as a clock enable instead of clocking flops from divided nets. The `locked` and `timeout` outputs report whether the divided clock is present and stable.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth (≥2).
- `CNT_W`, default 16: width of the period counter and of `period`.
- `LOCK_COUNT`, default 4: consecutive matching periods required to assert `locked`.
- `TOL`, default 1: allowed absolute period difference, in cycles, for a "match".

Ports:
- `clk`, input, 1 bit: system clock. All logic is on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset. It clears all state immediately.
- `div_in`, input, 1 bit: slow divided clock, asynchronous to `clk`.
- `tick`, output, 1 bit: one-cycle pulse per synchronised rising edge of `div_in`.
- `tick_fall`, output, 1 bit: one-cycle pulse per synchronised falling edge (see Configuration).
- `period`, output, `CNT_W` bits: last measured rise-to-rise interval, in `clk` cycles.
- `period_valid`, output, 1 bit: `period` holds a real measurement.
- `locked`, output, 1 bit: period stable within `TOL` for `LOCK_COUNT` consecutive measurements.
- `timeout`, output, 1 bit: one-cycle pulse when no rising edge arrives before the counter saturates.

## Operation
**Synchroniser and edge detect**
- `div_in` passes through a `SYNC_STAGES` flop chain to give `s`, plus one history flop `s_d`.
- `rise` = `s & ~s_d` and `fall` = `~s & s_d`.
- `tick` and `tick_fall` are registered copies of `rise` and `fall`.

**Counter**
- `cnt` is `CNT_W` bits.
- It is cleared to 0 on the cycle after `rise`, and increments by 1 on every other cycle while the state is not IDLE.
- It saturates at all-ones and never wraps.

**State machine** (states IDLE, FIRST, TRACK; reset state IDLE)
- IDLE: the counter is held at 0. On `rise` → FIRST.
- FIRST: on `rise`:
  - `period` ← `cnt+1`, `period_valid` ← 1, `match_cnt` ← 0.
  - → TRACK.
- TRACK: on `rise`:
  - `period` ← `cnt+1`.
  - If |(`cnt+1`) − old `period`| ≤ `TOL`: `match_cnt` increments, saturating at `LOCK_COUNT`.
  - Otherwise: `match_cnt` ← 0.
  - `locked` = (`match_cnt` == `LOCK_COUNT`), registered.
- Timeout: in FIRST or TRACK, if `cnt` reaches all-ones with no `rise` in that cycle:
  - `timeout` pulses for 1 cycle.
  - `period_valid`, `locked` and `match_cnt` are cleared; `period` holds its last value.
  - → IDLE.
- `rise` and saturation in the same cycle: `rise` wins and no timeout is raised.
- Period arithmetic: the difference is computed at `CNT_W+1` bits, so it never underflows.

**Reset**
- Every output and every internal register goes to 0: `tick` = 0, `tick_fall` = 0, `period` = 0, `period_valid` = 0, `locked` = 0, `timeout` = 0, and the synchroniser chain is 0.
- If `div_in` is high at reset release, that first high level produces a `tick` after `SYNC_STAGES+1` edges, because the chain resets to 0.
- Reset asserted mid-operation aborts the measurement. The next measurement starts from IDLE.

## Timing
- `div_in` 0→1 stable before clock edge k gives `tick` high for exactly the cycle after edge k+`SYNC_STAGES`. With the default, that is 3 edges of latency.
- `period`, `period_valid` and `locked` update on the same edge that raises `tick`.
- A square wave with a rise every N cycles (N ≥ 2, after sync) reads `period` = N.
- `period_valid` asserts on the 2nd detected rise.
- `locked` asserts on rise number `LOCK_COUNT+2`.
- `timeout` fires 2^`CNT_W`−1 cycles after the clear that followed the last `rise`.
- Edges closer than `SYNC_STAGES` cycles apart may be merged. This is not supported input.

## Configuration
- `DIV_TICK_FALL_EN` defined: the falling-edge path is built and `tick_fall` pulses per falling edge, with the same latency as `tick`.
- `DIV_TICK_FALL_EN` not defined: the fall logic is omitted and `tick_fall` is tied to 0.
- Rise path, measurement and lock behaviour are identical in both builds.

## Test plan
- Drive `div_in` from a ÷4 of `clk` for 10 rises → `tick` every 4 cycles, `period` = 4, `period_valid` from rise 2, `locked` from rise 6 (LOCK_COUNT = 4).
- Locked at 4, then intervals 5, 4, 5 → `locked` stays 1. Then one interval of 7 → `period` = 7 and `locked` = 0 on that `tick`. Relock after 4 further matches.
- `CNT_W` = 8: lock, then hold `div_in` low → one `timeout` pulse 255 cycles after the last `tick`, `period_valid` = `locked` = 0, `period` keeps its last value. The next two rises restore `period_valid`.
- `div_in` = 1 during and after reset → `tick` after 3 edges. Then the ÷4 stream resumes with a normal measurement.
- Assert `reset` for 1 cycle mid-TRACK → all outputs 0 immediately. Lock sequence restarts from IDLE.
- `DIV_TICK_FALL_EN` defined: with ÷4, `tick_fall` pulses 2 cycles after each `tick`. Undefined: `tick_fall` is constant 0.

Source files
------------

// File: rtl/div_tick_detect.sv
// Divided-clock receiver: synchronises div_in, emits edge ticks and tracks its period / lock.
// Optional falling-edge tick path is built when DIV_TICK_FALL_EN is defined.
module div_tick_detect #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TOL         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic             tick,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {StIdle, StFirst, StTrack} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic [MW-1:0]          match_q, match_d;
    logic                   locked_q, locked_d;
    logic                   tick_q, timeout_c;
    logic [CNT_W:0]         meas, diff;
    logic                   sat, in_tol;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            s_d      <= 1'b0;
            tick_q   <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], div_in};
            s_d      <= s;
            tick_q   <= rise;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

    // Widened by one bit so cnt+1 and the absolute difference never wrap.
    assign meas   = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
    assign diff   = (meas >= (CNT_W+1)'(period_q)) ? meas - (CNT_W+1)'(period_q)
                                                   : (CNT_W+1)'(period_q) - meas;
    assign in_tol = diff <= (CNT_W+1)'(TOL);
    assign sat    = &cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        match_d   = match_q;
        timeout_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) state_d = StFirst;
            end
            StFirst, StTrack: begin
                if (!sat) cnt_d = cnt_q + CNT_W'(1);
                if (rise) begin
                    cnt_d    = '0;
                    period_d = meas[CNT_W-1:0];
                    if (state_q == StFirst) begin
                        valid_d = 1'b1;
                        match_d = '0;
                        state_d = StTrack;
                    end else if (in_tol) begin
                        if (match_q != MW'(LOCK_COUNT)) match_d = match_q + MW'(1);
                    end else begin
                        match_d = '0;
                    end
                end else if (sat) begin
                    // Period keeps its last value so software can see what was lost.
                    timeout_c = 1'b1;
                    valid_d   = 1'b0;
                    match_d   = '0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        locked_d = (match_d == MW'(LOCK_COUNT));
    end

`ifdef DIV_TICK_FALL_EN
    logic fall, tick_fall_q;
    assign fall = ~s & s_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_fall_q <= 1'b0;
        else       tick_fall_q <= fall;
    end
    assign tick_fall = tick_fall_q;
`else
    assign tick_fall = 1'b0;
`endif

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    // Raised in the cycle the saturated count is seen, alongside the state clear.
    assign timeout      = timeout_c;

endmodule

// File: tb/tb_div_tick_detect.sv
// Directed, table-driven bench for div_tick_detect (CNT_W = 8 so the timeout is reachable).
module tb_div_tick_detect;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             div_in = 1'b0;
    logic             tick, tick_fall, period_valid, locked, timeout;
    logic [CNT_W-1:0] period;

    div_tick_detect #(
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .LOCK_COUNT (4),
        .TOL        (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .div_in      (div_in),
        .tick        (tick),
        .tick_fall   (tick_fall),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int exp_period;
        int exp_valid;
        int exp_locked;
    } vec_t;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int last_tick_cyc = 0;
    int ticks, falls_total;
    int cap_period, cap_valid, cap_locked;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tick) begin
            ticks++;
            last_tick_cyc = cyc;
            cap_period = int'(period);
            cap_valid  = int'(period_valid);
            cap_locked = int'(locked);
        end
        if (tick_fall) falls_total++;
    endtask

    // One div_in period: hi cycles high then lo cycles low; exactly one tick expected inside.
    task automatic apply_vec(input string tag, input vec_t v);
        ticks = 0;
        cap_period = -1; cap_valid = -1; cap_locked = -1;
        div_in = 1'b1;
        for (int i = 0; i < v.hi; i++) step();
        div_in = 1'b0;
        for (int i = 0; i < v.lo; i++) step();
        check({tag, " tick count"}, ticks, 1);
        check({tag, " period"}, cap_period, v.exp_period);
        check({tag, " period_valid"}, cap_valid, v.exp_valid);
        check({tag, " locked"}, cap_locked, v.exp_locked);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " tick"}, int'(tick), 0);
        check({tag, " tick_fall"}, int'(tick_fall), 0);
        check({tag, " period"}, int'(period), 0);
        check({tag, " period_valid"}, int'(period_valid), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " timeout"}, int'(timeout), 0);
    endtask

    vec_t tbl[20];
    vec_t v4;

    initial begin
        int found, exp_falls;

        // Rise i reports the length of interval i-1.
        tbl[0]  = '{2, 2, 0, 0, 0};
        tbl[1]  = '{2, 2, 4, 1, 0};
        tbl[2]  = '{2, 2, 4, 1, 0};
        tbl[3]  = '{2, 2, 4, 1, 0};
        tbl[4]  = '{2, 2, 4, 1, 0};
        tbl[5]  = '{2, 2, 4, 1, 1};
        tbl[6]  = '{2, 2, 4, 1, 1};
        tbl[7]  = '{2, 2, 4, 1, 1};
        tbl[8]  = '{2, 2, 4, 1, 1};
        tbl[9]  = '{2, 2, 4, 1, 1};
        tbl[10] = '{2, 3, 4, 1, 1};
        tbl[11] = '{2, 2, 5, 1, 1};
        tbl[12] = '{2, 3, 4, 1, 1};
        tbl[13] = '{3, 4, 5, 1, 1};
        tbl[14] = '{2, 2, 7, 1, 0};
        tbl[15] = '{2, 2, 4, 1, 0};
        tbl[16] = '{2, 2, 4, 1, 0};
        tbl[17] = '{2, 2, 4, 1, 0};
        tbl[18] = '{2, 2, 4, 1, 0};
        tbl[19] = '{2, 2, 4, 1, 1};
        falls_total = 0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        reset = 1'b0;
        step();

        for (int i = 0; i < 20; i++) apply_vec($sformatf("main[%0d]", i), tbl[i]);

        // Hold low: timeout 255 cycles after the last tick (the counter clear)
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (timeout) found = cyc;
        end
        check("timeout seen", int'(found != 0), 1);
        check("timeout distance", found - last_tick_cyc, 255);
        check("timeout valid before clear", int'(period_valid), 1);
        step();
        check("timeout one-cycle", int'(timeout), 0);
        check("after timeout valid", int'(period_valid), 0);
        check("after timeout locked", int'(locked), 0);
        check("after timeout period", int'(period), 4);

        v4 = '{2, 2, 4, 0, 0};
        apply_vec("post-timeout rise1", v4);
        v4 = '{2, 2, 4, 1, 0};
        apply_vec("post-timeout rise2", v4);

        // div_in high across reset release
        #1;
        div_in = 1'b1;
        reset  = 1'b1;
        #1;
        check_all_zero("reset with div_in high");
        step();
        step();
        reset = 1'b0;
        ticks = 0;
        step();
        check("high release edge1 tick", int'(tick), 0);
        step();
        check("high release edge2 tick", int'(tick), 0);
        step();
        check("high release edge3 tick", int'(tick), 1);
        check("high release valid", int'(period_valid), 0);
        div_in = 1'b0;
        step();
        apply_vec("resume[0]", tbl[1]);
        for (int i = 2; i <= 5; i++) apply_vec($sformatf("resume[%0d]", i - 1), tbl[i]);

        // One-cycle reset mid-TRACK while locked
        reset = 1'b1;
        #1;
        check_all_zero("mid reset");
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 6; i++) apply_vec($sformatf("relock[%0d]", i), tbl[i]);

`ifdef DIV_TICK_FALL_EN
        exp_falls = 1;
`else
        exp_falls = 0;
`endif
        // With the fall path built, check one pulse 2 cycles after a tick on a div-4 stream.
        ticks = 0;
        falls_total = 0;
        found = 0;
        div_in = 1'b1;
        step(); step();
        div_in = 1'b0;
        step();
        check("fall probe tick", int'(tick), 1);
        step();
        step();
        found = int'(tick_fall);
        step(); step(); step();
        check("tick_fall 2 after tick", found, exp_falls);
        check("tick_fall count", falls_total, exp_falls);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
